// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: parity mode and receiver FSM states.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR,
        STOP
    } rx_state_e;

endpackage

// File: rtl/bit_capture_reg.sv
// Register whose bits are written one at a time by index; untouched bits keep their value.
module bit_capture_reg #(
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [$clog2(W)-1:0] idx,
    input  logic                 din,
    output logic [W-1:0]         q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q[idx] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// UART frame deserialiser: samples start/data/parity/stop at baud strobes and
// hands each finished word to a valid/ready consumer with error and overrun flags.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int      DATA_W    = 8,
    parameter parity_e PARITY    = PAR_NONE,
    parameter bit      MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic              uart_rx,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

    rx_state_e         state;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  bit_idx;
    logic [DATA_W-1:0] buf_q;
    logic              par_bad;
    logic              par_calc;
    logic              buf_clear;
    logic              buf_load;
    logic              commit;

    assign bit_idx   = MSB_FIRST ? (LAST_IDX - count) : count;
    assign buf_clear = sample_en && (state == IDLE) && !uart_rx;
    assign buf_load  = sample_en && (state == DATA);
    assign commit    = sample_en && (state == STOP);
    assign par_calc  = (^buf_q) ^ uart_rx;

    // A detected start bit wipes the capture buffer through its own reset input.
    bit_capture_reg #(
        .W(DATA_W)
    ) u_capture (
        .clk  (clk),
        .rst  (rst || buf_clear),
        .load (buf_load),
        .idx  (bit_idx),
        .din  (uart_rx),
        .q    (buf_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            par_bad    <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (sample_en) begin
                unique case (state)
                    IDLE: begin
                        if (!uart_rx) begin
                            state   <= DATA;
                            count   <= '0;
                            par_bad <= 1'b0;
                        end
                    end
                    DATA: begin
                        count <= count + 1'b1;
                        if (count == LAST_IDX) begin
                            state <= (PARITY != PAR_NONE) ? PAR : STOP;
                        end
                    end
                    PAR: begin
                        par_bad <= (PARITY == PAR_EVEN) ? par_calc : ~par_calc;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end

            // A commit in the same cycle as an accept wins, and the old word counts as taken.
            if (valid && ready) begin
                valid      <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
                overrun    <= 1'b0;
            end
            if (commit) begin
                data       <= buf_q;
                valid      <= 1'b1;
                parity_err <= par_bad;
                frame_err  <= ~uart_rx;
                overrun    <= valid && !ready;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: three configurations (8N LSB-first, 8E LSB-first,
// 7N MSB-first) driven from a shared strobe, checked through an expected-result queue.
module tb_uart_rx_deser;
    import uart_pkg::*;

    typedef struct {
        logic [8:0] data;
        logic       valid;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } out_t;

    typedef struct {
        int   dut;
        out_t o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_en;
    logic       rx  [3];
    logic       rdy [3];
    logic [7:0] data0;
    logic [7:0] data1;
    logic [6:0] data2;
    logic       v   [3];
    logic       pe  [3];
    logic       fe  [3];
    logic       ov  [3];

    exp_t       sb_q [$];
    logic [8:0] model_data  [3];
    logic       model_valid [3];
    int         checks = 0;
    int         fails  = 0;

    always #5 clk = ~clk;

    uart_rx_deser #(.DATA_W(8), .PARITY(PAR_NONE), .MSB_FIRST(1'b0)) dut_none (
        .clk(clk), .rst(rst), .sample_en(sample_en), .uart_rx(rx[0]), .ready(rdy[0]),
        .data(data0), .valid(v[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0])
    );

    uart_rx_deser #(.DATA_W(8), .PARITY(PAR_EVEN), .MSB_FIRST(1'b0)) dut_even (
        .clk(clk), .rst(rst), .sample_en(sample_en), .uart_rx(rx[1]), .ready(rdy[1]),
        .data(data1), .valid(v[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1])
    );

    uart_rx_deser #(.DATA_W(7), .PARITY(PAR_NONE), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .sample_en(sample_en), .uart_rx(rx[2]), .ready(rdy[2]),
        .data(data2), .valid(v[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2])
    );

    function automatic out_t sampleOut(int d);
        out_t o;
        case (d)
            0:       o.data = {1'b0, data0};
            1:       o.data = {1'b0, data1};
            default: o.data = {2'b00, data2};
        endcase
        o.valid = v[d];
        o.perr  = pe[d];
        o.ferr  = fe[d];
        o.ovr   = ov[d];
        return o;
    endfunction

    task automatic compareField(string tag, logic [8:0] obs, logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(string tag, int d, out_t e);
        out_t o;
        o = sampleOut(d);
        compareField({tag, ".data"},       o.data,           e.data);
        compareField({tag, ".valid"},      {8'b0, o.valid},  {8'b0, e.valid});
        compareField({tag, ".parity_err"}, {8'b0, o.perr},   {8'b0, e.perr});
        compareField({tag, ".frame_err"},  {8'b0, o.ferr},   {8'b0, e.ferr});
        compareField({tag, ".overrun"},    {8'b0, o.ovr},    {8'b0, e.ovr});
    endtask

    task automatic strobe(int d, logic b);
        @(negedge clk);
        rx[d]     = b;
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
    endtask

    // Data, optional parity and stop bits; the expected result is queued at the stop strobe.
    task automatic sendBody(int d, logic [8:0] word, int nbits, bit msb, bit has_par,
                            logic par_bit, logic stop_bit, logic ready_at_stop);
        exp_t e;
        for (int i = 0; i < nbits; i++) begin
            strobe(d, msb ? word[nbits-1-i] : word[i]);
        end
        if (has_par) strobe(d, par_bit);
        @(negedge clk);
        rx[d]     = stop_bit;
        rdy[d]    = ready_at_stop;
        sample_en = 1'b1;
        compareField("pre_commit.valid", {8'b0, v[d]}, {8'b0, model_valid[d]});
        e.dut     = d;
        e.o.data  = word;
        e.o.valid = 1'b1;
        e.o.perr  = has_par ? ((^word) ^ par_bit) : 1'b0;
        e.o.ferr  = ~stop_bit;
        e.o.ovr   = model_valid[d] && !ready_at_stop;
        sb_q.push_back(e);
        model_valid[d] = 1'b1;
        model_data[d]  = word;
        @(negedge clk);
        sample_en = 1'b0;
        rdy[d]    = 1'b0;
    endtask

    task automatic applyStimulus(int d, logic [8:0] word, int nbits, bit msb, bit has_par,
                                 logic par_bit, logic stop_bit, logic ready_at_stop);
        strobe(d, 1'b0);
        sendBody(d, word, nbits, msb, has_par, par_bit, stop_bit, ready_at_stop);
    endtask

    task automatic checkFrame(string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL %s: observed empty scoreboard expected a queued frame", tag);
        end else begin
            e = sb_q.pop_front();
            checkOutput(tag, e.dut, e.o);
        end
    endtask

    task automatic acceptWord(int d, string tag);
        out_t e;
        @(negedge clk);
        rdy[d] = 1'b1;
        @(negedge clk);
        rdy[d] = 1'b0;
        model_valid[d] = 1'b0;
        e = '{data: model_data[d], valid: 1'b0, perr: 1'b0, ferr: 1'b0, ovr: 1'b0};
        checkOutput(tag, d, e);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            model_data[i]  = '0;
            model_valid[i] = 1'b0;
        end
        sb_q.delete();
    endtask

    initial begin
        out_t zero_out;
        zero_out  = '{data: 9'h000, valid: 1'b0, perr: 1'b0, ferr: 1'b0, ovr: 1'b0};
        rst       = 1'b1;
        sample_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx[i]          = 1'b1;
            rdy[i]         = 1'b0;
            model_data[i]  = '0;
            model_valid[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        checkOutput("reset.none", 0, zero_out);
        checkOutput("reset.even", 1, zero_out);
        checkOutput("reset.msb",  2, zero_out);

        applyStimulus(0, 9'h055, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkFrame("frame55");
        acceptWord(0, "accept55");

        applyStimulus(1, 9'h0A3, 8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkFrame("parA3_bad");
        acceptWord(1, "acceptA3_bad");
        applyStimulus(1, 9'h0A3, 8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkFrame("parA3_good");
        acceptWord(1, "acceptA3_good");

        applyStimulus(0, 9'h00F, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkFrame("break0F");
        acceptWord(0, "accept0F");
        strobe(0, 1'b0);
        sendBody(0, 9'h05A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkFrame("after_break5A");
        acceptWord(0, "accept5A");

        applyStimulus(0, 9'h011, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkFrame("frame11");
        applyStimulus(0, 9'h022, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkFrame("overrun22");
        acceptWord(0, "accept22");

        applyStimulus(0, 9'h033, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkFrame("frame33");
        applyStimulus(0, 9'h044, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkFrame("commit_accept44");
        acceptWord(0, "accept44");

        strobe(0, 1'b0);
        strobe(0, 1'b1);
        strobe(0, 1'b1);
        strobe(0, 1'b0);
        strobe(0, 1'b1);
        applyReset();
        checkOutput("midframe_reset", 0, zero_out);
        applyStimulus(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkFrame("frame3C");
        acceptWord(0, "accept3C");

        applyStimulus(2, 9'h041, 7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkFrame("msb41");
        acceptWord(2, "accept41");
        applyStimulus(2, 9'h00B, 7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkFrame("msb0B");

        checks++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: observed %0d entries expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_deser.md
UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001 Parameter DATA_W, default 8: data bits per frame, legal range 5..9.
REQ-002 Parameter PARITY, default PAR_NONE: parity mode, one of PAR_NONE, PAR_EVEN or PAR_ODD.
REQ-003 Parameter MSB_FIRST, default 0: 0 = first data bit is data[0]; 1 = first data bit is data[DATA_W-1].
REQ-004 clk  input  1  single clock, all state on rising edge; one clock, no other clock domains.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 sample_en  input  1  one-cycle strobe at each bit centre, from the baud generator.
REQ-007 uart_rx  input  1  serial line, idle high, already synchronised to clk.
REQ-008 ready  input  1  consumer accepts the word in any cycle with valid&ready.
REQ-009 data  output  DATA_W  last committed word.
REQ-010 valid  output  1  data holds an unaccepted word.
REQ-011 parity_err  output  1  committed word failed the parity check; always 0 when PARITY=PAR_NONE.
REQ-012 frame_err  output  1  committed word had stop bit sampled 0.
REQ-013 overrun  output  1  committed word replaced an unaccepted word.

Function
REQ-014 FSM states are IDLE, DATA, PAR and STOP; state changes only in cycles with sample_en=1.
REQ-015 IDLE: sample_en with uart_rx=0 (start bit) -> DATA, bit counter cleared, capture buffer cleared; uart_rx=1 -> stay IDLE.
REQ-016 DATA: each sample_en writes uart_rx into only the addressed buffer bit (index = count if MSB_FIRST=0, else DATA_W-1-count); all other bits hold.
REQ-017 DATA: after the DATA_W-th sample -> PAR if PARITY!=PAR_NONE, else STOP.
REQ-018 PAR: p = XOR(buffer bits) ^ uart_rx; error when p=1 for PAR_EVEN and when p=0 for PAR_ODD; the result is held until commit; -> STOP.
REQ-019 STOP: sample_en commits the frame and moves to IDLE; uart_rx=0 sets frame_err for that word, and the word is still delivered.
REQ-020 Commit latency: data, valid=1 and the error flags update in the clock cycle after the stop-bit sample_en.
REQ-021 The capture buffer and the output register are separate; data, valid and the flags stay stable while the next frame is received.
REQ-022 valid&ready with no commit in the same cycle: valid=0 next cycle, and flags cleared.
REQ-023 Commit while valid=1 and ready=0: data overwritten with the new word, overrun=1, valid stays 1.
REQ-024 Commit while valid=1 and ready=1: the old word counts as accepted, the new word loads, overrun=0.
REQ-025 Break (line held low): a frame with frame_err is committed; because the line is still low, the next sample_en in IDLE starts a new frame.
REQ-026 sample_en=0: FSM, counter and buffer hold; the handshake still operates every cycle.

Reset
REQ-027 rst=1 at a clock edge: state=IDLE, counter=0, buffer=0, data=0, valid=0, parity_err=0, frame_err=0, overrun=0.
REQ-028 rst has priority over sample_en and ready; a frame in progress at reset is discarded and never committed.

Structure
REQ-029 Package uart_pkg holds the parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD) and the rx_state_e enum.
REQ-030 One sub-module, bit_capture_reg #(W): a per-bit addressed load register with ports clk, rst, load, idx, din and q, instantiated once for the capture buffer.
REQ-031 The counter width is $clog2(DATA_W); there is no arithmetic on widths beyond the counter compare against DATA_W-1.

Verification
REQ-032 DATA_W=8, PARITY=PAR_NONE, LSB-first; serial frame 0,1,0,1,0,1,0,1,0,1 -> data=0x55 and valid=1 one cycle after the stop strobe, all error flags 0.
REQ-033 PARITY=PAR_EVEN; word 0xA3 sent with parity bit 1 -> data=0xA3, parity_err=1; resent with parity bit 0 -> parity_err=0.
REQ-034 Frame 0x0F with stop bit 0 -> data=0x0F, frame_err=1, valid=1; holding the line low starts a new frame on the next strobe.
REQ-035 ready=0; frames 0x11 then 0x22 -> data=0x22, overrun=1; then ready=1 for one cycle -> valid=0 and overrun=0 next cycle.
REQ-036 rst pulsed after 4 data bits, then a full frame 0x3C -> no commit of the partial frame; data=0x3C, no errors.
REQ-037 DATA_W=7, MSB_FIRST=1; data bits 1,0,0,0,0,0,1 -> data=0x41.
